// File: rtl/stack_pkg.sv
// stack_pkg: shared types and constants for the stack controller.
//   state_t - controller FSM states
//   OP_PUSH / OP_POP - encoding of the sp module's op input (also used by the sp bench)
package stack_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PUSH    = 3'd1,
        POP_DEC = 3'd2,
        POP_RD  = 3'd3,
        POP_CAP = 3'd4
    } state_t;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

endpackage

// File: rtl/stack_ctrl_if.sv
// stack_ctrl_if: requester-side handshake between a client and stack_ctrl.
//   push_req/push_data/pop_req   - requests from the client
//   ready                        - controller idle, request can be accepted
//   pop_data/pop_valid           - popped word and its one-cycle strobe
//   full/empty/err               - occupancy flags and rejected-request pulse
// modport master: the requester; modport slave: the controller.
interface stack_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             push_req;
    logic [WIDTH-1:0] push_data;
    logic             pop_req;
    logic             ready;
    logic [WIDTH-1:0] pop_data;
    logic             pop_valid;
    logic             full;
    logic             empty;
    logic             err;

    modport master (
        output push_req, push_data, pop_req,
        input  ready, pop_data, pop_valid, full, empty, err
    );

    modport slave (
        input  push_req, push_data, pop_req,
        output ready, pop_data, pop_valid, full, empty, err
    );
endinterface

// File: rtl/stack_ctrl.sv
// stack_ctrl: push/pop sequencer between a requester, the sp pointer register
// and a single-port synchronous-read stack RAM.
//   clk, rst_n  - clock, asynchronous active-low reset
//   req         - requester handshake (stack_ctrl_if.slave)
//   sp          - current stack pointer (next free slot) from the sp module
//   sp_we/sp_op - sp update strobe and direction (OP_PUSH increments)
//   mem_*       - RAM address/write strobe/write data/read data (1-cycle read)
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int unsigned BITS  = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    stack_ctrl_if.slave       req,
    input  logic [BITS-1:0]   sp,
    output logic              sp_we,
    output logic              sp_op,
    output logic [BITS-1:0]   mem_addr,
    output logic              mem_we,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata
);

    // depth carries one extra bit so a completely full stack is distinguishable from empty
    localparam int unsigned DW  = BITS + 1;
    localparam int unsigned CAP = 2 ** BITS;

    state_t           state, state_nxt;
    logic [DW-1:0]    depth, depth_nxt;
    logic [WIDTH-1:0] data_q;
    logic             accept_push;
    logic             reject;

    // Addressing is always relative to the live pointer: write at sp on push,
    // read at the already-decremented sp on pop.
    assign mem_addr  = sp;
    assign mem_wdata = data_q;

    // Next-state, occupancy and request decode
    always_comb begin
        state_nxt   = state;
        depth_nxt   = depth;
        accept_push = 1'b0;
        reject      = 1'b0;
        case (state)
            IDLE: begin
                // push wins a tie; a concurrent pop waits for ready
                if (req.push_req) begin
                    if (!req.full) begin
                        state_nxt   = PUSH;
                        accept_push = 1'b1;
                    end else begin
                        reject = 1'b1;
                    end
                end else if (req.pop_req) begin
                    if (!req.empty) begin
                        state_nxt = POP_DEC;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            PUSH: begin
                state_nxt = IDLE;
                depth_nxt = depth + DW'(1);
            end
            POP_DEC: begin
                state_nxt = POP_RD;
                depth_nxt = depth - DW'(1);
            end
            POP_RD:  state_nxt = POP_CAP;
            POP_CAP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, occupancy and registered outputs; strobes are pre-decoded from
    // state_nxt so they are valid for the whole cycle the FSM sits in a state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            depth         <= '0;
            data_q        <= '0;
            req.ready     <= 1'b1;
            req.full      <= 1'b0;
            req.empty     <= 1'b1;
            req.err       <= 1'b0;
            req.pop_valid <= 1'b0;
            req.pop_data  <= '0;
            sp_we         <= 1'b0;
            sp_op         <= OP_POP;
            mem_we        <= 1'b0;
        end else begin
            state         <= state_nxt;
            depth         <= depth_nxt;
            req.ready     <= (state_nxt == IDLE);
            req.full      <= (depth_nxt == DW'(CAP));
            req.empty     <= (depth_nxt == '0);
            req.err       <= reject;
            req.pop_valid <= (state == POP_CAP);
            if (state == POP_CAP) begin
                req.pop_data <= mem_rdata;
            end
            if (accept_push) begin
                data_q <= req.push_data;
            end
            sp_we  <= (state_nxt == PUSH) || (state_nxt == POP_DEC);
            sp_op  <= (state_nxt == PUSH) ? OP_PUSH : OP_POP;
            mem_we <= (state_nxt == PUSH);
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: self-checking bench for stack_ctrl with a behavioural sp
// register, a synchronous-read RAM and a queue-based LIFO reference model.
module tb_stack_ctrl;
    import stack_pkg::*;

    localparam int unsigned BITS  = 2;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned CAP   = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    stack_ctrl_if #(.WIDTH(WIDTH)) bus ();

    logic [BITS-1:0]  sp_r = BITS'($urandom_range(0, CAP - 1));
    logic             sp_we, sp_op, mem_we;
    logic [BITS-1:0]  mem_addr;
    logic [WIDTH-1:0] mem_wdata, mem_rdata;
    logic [WIDTH-1:0] mem [CAP];

    stack_ctrl #(.BITS(BITS), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (bus),
        .sp        (sp_r),
        .sp_we     (sp_we),
        .sp_op     (sp_op),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // sp register stand-in (never reset)
    always @(posedge clk) begin
        if (sp_we) sp_r <= (sp_op == OP_PUSH) ? BITS'(sp_r + 1) : BITS'(sp_r - 1);
    end

    // synchronous-read single-port RAM
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    // strobe counters
    int sp_we_cnt = 0;
    int mem_we_cnt = 0;
    int pv_cnt = 0;
    always @(posedge clk) begin
        if (sp_we)         sp_we_cnt  <= sp_we_cnt + 1;
        if (mem_we)        mem_we_cnt <= mem_we_cnt + 1;
        if (bus.pop_valid) pv_cnt     <= pv_cnt + 1;
    end

    logic [WIDTH-1:0] model_q[$];
    int total = 0;
    int bad = 0;

    task automatic do_push(input logic [WIDTH-1:0] d);
        logic [BITS-1:0] sp0;
        sp0 = sp_r;
        bus.push_req = 1'b1;
        bus.push_data = d;
        @(negedge clk);
        total++;
        if (bus.ready !== 1'b0 || mem_we !== 1'b1 || sp_we !== 1'b1 || sp_op !== OP_PUSH ||
            mem_addr !== sp0 || mem_wdata !== d) begin
            bad++;
            $display("FAIL push_cycle: ready=%b mem_we=%b sp_we=%b sp_op=%b addr=%0d wdata=%h required 0 1 1 1 %0d %h",
                     bus.ready, mem_we, sp_we, sp_op, mem_addr, mem_wdata, sp0, d);
        end
        bus.push_req = 1'b0;
        @(negedge clk);
        model_q.push_back(d);
        total++;
        if (bus.ready !== 1'b1 || sp_r !== BITS'(sp0 + 1) || mem[sp0] !== d || bus.empty !== 1'b0 ||
            bus.full !== (model_q.size() == CAP) || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL push_done: ready=%b sp=%0d mem=%h empty=%b full=%b required 1 %0d %h 0 %b",
                     bus.ready, sp_r, mem[sp0], bus.empty, bus.full, BITS'(sp0 + 1), d, model_q.size() == CAP);
        end
    endtask

    task automatic do_pop();
        logic [BITS-1:0]  sp0;
        logic [WIDTH-1:0] exp;
        sp0 = sp_r;
        exp = model_q[model_q.size() - 1];
        bus.pop_req = 1'b1;
        @(negedge clk);
        total++;
        if (bus.ready !== 1'b0 || sp_we !== 1'b1 || sp_op !== OP_POP || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL pop_dec: ready=%b sp_we=%b sp_op=%b mem_we=%b required 0 1 0 0",
                     bus.ready, sp_we, sp_op, mem_we);
        end
        bus.pop_req = 1'b0;
        @(negedge clk);
        total++;
        if (sp_r !== BITS'(sp0 - 1) || mem_addr !== BITS'(sp0 - 1) || sp_we !== 1'b0 ||
            bus.ready !== 1'b0 || bus.pop_valid !== 1'b0) begin
            bad++;
            $display("FAIL pop_rd: sp=%0d addr=%0d sp_we=%b ready=%b pv=%b required %0d %0d 0 0 0",
                     sp_r, mem_addr, sp_we, bus.ready, bus.pop_valid, BITS'(sp0 - 1), BITS'(sp0 - 1));
        end
        @(negedge clk);
        total++;
        if (bus.ready !== 1'b0 || bus.pop_valid !== 1'b0) begin
            bad++;
            $display("FAIL pop_cap: ready=%b pv=%b required 0 0", bus.ready, bus.pop_valid);
        end
        model_q.pop_back();
        @(negedge clk);
        total++;
        if (bus.pop_valid !== 1'b1 || bus.pop_data !== exp || bus.ready !== 1'b1 ||
            bus.empty !== (model_q.size() == 0) || bus.full !== 1'b0) begin
            bad++;
            $display("FAIL pop_out: pv=%b data=%h ready=%b empty=%b full=%b required 1 %h 1 %b 0",
                     bus.pop_valid, bus.pop_data, bus.ready, bus.empty, bus.full, exp, model_q.size() == 0);
        end
        @(negedge clk);
        total++;
        if (bus.pop_valid !== 1'b0 || bus.pop_data !== exp) begin
            bad++;
            $display("FAIL pop_hold: pv=%b data=%h required 0 %h", bus.pop_valid, bus.pop_data, exp);
        end
    endtask

    task automatic reject_push();
        logic [BITS-1:0] sp0;
        int s0, m0;
        sp0 = sp_r; s0 = sp_we_cnt; m0 = mem_we_cnt;
        bus.push_req = 1'b1;
        bus.push_data = WIDTH'($urandom);
        @(negedge clk);
        total++;
        if (bus.err !== 1'b1 || bus.ready !== 1'b1 || sp_r !== sp0 || bus.full !== 1'b1) begin
            bad++;
            $display("FAIL push_full_err: err=%b ready=%b sp=%0d full=%b required 1 1 %0d 1",
                     bus.err, bus.ready, sp_r, bus.full, sp0);
        end
        bus.push_req = 1'b0;
        @(negedge clk);
        total++;
        if (bus.err !== 1'b0 || sp_r !== sp0 || sp_we_cnt !== s0 || mem_we_cnt !== m0) begin
            bad++;
            $display("FAIL push_full_after: err=%b sp=%0d sp_we_cnt=%0d mem_we_cnt=%0d required 0 %0d %0d %0d",
                     bus.err, sp_r, sp_we_cnt, mem_we_cnt, sp0, s0, m0);
        end
    endtask

    task automatic reject_pop();
        logic [BITS-1:0] sp0;
        int s0, m0;
        sp0 = sp_r; s0 = sp_we_cnt; m0 = mem_we_cnt;
        bus.pop_req = 1'b1;
        @(negedge clk);
        total++;
        if (bus.err !== 1'b1 || bus.ready !== 1'b1 || sp_r !== sp0 || bus.empty !== 1'b1) begin
            bad++;
            $display("FAIL pop_empty_err: err=%b ready=%b sp=%0d empty=%b required 1 1 %0d 1",
                     bus.err, bus.ready, sp_r, bus.empty, sp0);
        end
        bus.pop_req = 1'b0;
        @(negedge clk);
        total++;
        if (bus.err !== 1'b0 || sp_r !== sp0 || sp_we_cnt !== s0 || mem_we_cnt !== m0) begin
            bad++;
            $display("FAIL pop_empty_after: err=%b sp=%0d sp_we_cnt=%0d mem_we_cnt=%0d required 0 %0d %0d %0d",
                     bus.err, sp_r, sp_we_cnt, mem_we_cnt, sp0, s0, m0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.push_req = 1'b0;
        bus.pop_req = 1'b0;
        bus.push_data = '0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.ready !== 1'b1 || bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.err !== 1'b0 ||
            bus.pop_valid !== 1'b0 || bus.pop_data !== '0 || sp_we !== 1'b0 || mem_we !== 1'b0 ||
            sp_op !== 1'b0 || mem_addr !== sp_r) begin
            bad++;
            $display("FAIL reset_state: ready=%b empty=%b full=%b err=%b pv=%b pd=%h sp_we=%b mem_we=%b sp_op=%b addr=%0d sp=%0d",
                     bus.ready, bus.empty, bus.full, bus.err, bus.pop_valid, bus.pop_data,
                     sp_we, mem_we, sp_op, mem_addr, sp_r);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.ready !== 1'b1 || bus.empty !== 1'b1 || sp_we !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: ready=%b empty=%b sp_we=%b required 1 1 0", bus.ready, bus.empty, sp_we);
        end
    endtask

    task automatic test_push_pop_basic();
        logic [BITS-1:0] base;
        base = sp_r;
        do_push(8'h11);
        do_push(8'h22);
        total++;
        if (sp_r !== BITS'(base + 2) || mem[base] !== 8'h11 || mem[BITS'(base + 1)] !== 8'h22 ||
            bus.empty !== 1'b0 || model_q.size() != 2) begin
            bad++;
            $display("FAIL basic_two_push: sp=%0d mem0=%h mem1=%h empty=%b required %0d 11 22 0",
                     sp_r, mem[base], mem[BITS'(base + 1)], bus.empty, BITS'(base + 2));
        end
        do_pop();
        do_pop();
        total++;
        if (sp_r !== base || bus.empty !== 1'b1) begin
            bad++;
            $display("FAIL basic_two_pop: sp=%0d empty=%b required %0d 1", sp_r, bus.empty, base);
        end
    endtask

    task automatic test_full_reject();
        for (int i = 0; i < CAP; i++) do_push(WIDTH'($urandom));
        reject_push();
        while (model_q.size() > 0) do_pop();
    endtask

    task automatic test_empty_reject();
        reject_pop();
    endtask

    task automatic test_simultaneous();
        do_push(WIDTH'($urandom));
        bus.push_req = 1'b1;
        bus.push_data = 8'hAA;
        bus.pop_req = 1'b1;
        @(negedge clk);
        total++;
        if (mem_we !== 1'b1 || sp_op !== OP_PUSH || mem_wdata !== 8'hAA || bus.ready !== 1'b0) begin
            bad++;
            $display("FAIL simul_push_wins: mem_we=%b sp_op=%b wdata=%h ready=%b required 1 1 aa 0",
                     mem_we, sp_op, mem_wdata, bus.ready);
        end
        bus.push_req = 1'b0;
        @(negedge clk);
        model_q.push_back(8'hAA);
        total++;
        if (bus.ready !== 1'b1 || bus.empty !== 1'b0 || bus.pop_valid !== 1'b0) begin
            bad++;
            $display("FAIL simul_ready: ready=%b empty=%b pv=%b required 1 0 0", bus.ready, bus.empty, bus.pop_valid);
        end
        do_pop();
        do_pop();
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] d;
        int m0;
        m0 = mem_we_cnt;
        bus.push_req = 1'b1;
        for (int k = 0; k < CAP; k++) begin
            d = WIDTH'($urandom);
            bus.push_data = d;
            @(negedge clk);
            total++;
            if (mem_we !== 1'b1 || mem_wdata !== d || bus.ready !== 1'b0) begin
                bad++;
                $display("FAIL b2b_push%0d: mem_we=%b wdata=%h ready=%b required 1 %h 0", k, mem_we, mem_wdata, bus.ready, d);
            end
            model_q.push_back(d);
            @(negedge clk);
            if (k == CAP - 1) bus.push_req = 1'b0;
            total++;
            if (bus.ready !== 1'b1 || mem_we !== 1'b0) begin
                bad++;
                $display("FAIL b2b_idle%0d: ready=%b mem_we=%b required 1 0", k, bus.ready, mem_we);
            end
        end
        total++;
        if (bus.full !== 1'b1 || mem_we_cnt !== m0 + CAP) begin
            bad++;
            $display("FAIL b2b_full: full=%b writes=%0d required 1 %0d", bus.full, mem_we_cnt - m0, CAP);
        end
        while (model_q.size() > 0) do_pop();
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                if (model_q.size() == CAP) reject_push();
                else do_push(WIDTH'($urandom));
            end else begin
                if (model_q.size() == 0) reject_pop();
                else do_pop();
            end
        end
    endtask

    task automatic test_reset_midpop();
        int pv0, s0;
        if (model_q.size() == 0) do_push(WIDTH'($urandom));
        bus.pop_req = 1'b1;
        @(negedge clk);
        bus.pop_req = 1'b0;
        @(negedge clk);
        pv0 = pv_cnt;
        rst_n = 1'b0;
        model_q.delete();
        #1;
        total++;
        if (bus.ready !== 1'b1 || bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.pop_valid !== 1'b0 ||
            bus.pop_data !== '0 || sp_we !== 1'b0 || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL midpop_reset: ready=%b empty=%b full=%b pv=%b pd=%h sp_we=%b mem_we=%b",
                     bus.ready, bus.empty, bus.full, bus.pop_valid, bus.pop_data, sp_we, mem_we);
        end
        s0 = sp_we_cnt;
        bus.push_req = 1'b1;
        bus.push_data = 8'h5A;
        repeat (3) @(negedge clk);
        bus.push_req = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.ready !== 1'b1 || bus.empty !== 1'b1 || bus.pop_valid !== 1'b0 ||
            pv_cnt !== pv0 || sp_we_cnt !== s0) begin
            bad++;
            $display("FAIL midpop_release: ready=%b empty=%b pv=%b pv_cnt=%0d sp_we_cnt=%0d required 1 1 0 %0d %0d",
                     bus.ready, bus.empty, bus.pop_valid, pv_cnt, sp_we_cnt, pv0, s0);
        end
        test_empty_reject();
    endtask

    initial begin
        test_reset();
        test_push_pop_basic();
        test_full_reject();
        test_empty_reject();
        test_simultaneous();
        test_back_to_back();
        test_random();
        test_reset_midpop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
